// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit. It handles one outstanding memory access
//            with lane steering and a wait timeout. Optional build macro
//            LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Revision : 1.0
// ============================================================================
module lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        lsu_load,
  input  logic        lsu_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_fault,
  output logic        lsu_misalign,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned     c_cnt_w = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           off_q, off_d;
  logic                 load_q, load_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 fault_q, fault_d;
  logic                 mis_q, mis_d;

  logic                 w_accept;
  logic                 w_is_byte;
  logic                 w_is_half;
  logic                 w_misalign;
  logic [1:0]           w_off;
  logic [31:0]          w_lane;
  logic [31:0]          w_load_ext;

  // Request decode; the offset is truncated to the access alignment.
  always_comb begin
    w_accept  = (state_q == S_IDLE) && lsu_valid && (lsu_load ^ lsu_store);
    w_is_byte = (lsu_funct3 == 3'b000) || (lsu_load && (lsu_funct3 == 3'b100));
    w_is_half = (lsu_funct3 == 3'b001) || (lsu_load && (lsu_funct3 == 3'b101));
    if (w_is_byte) begin
      w_off = lsu_addr[1:0];
    end else if (w_is_half) begin
      w_off = {lsu_addr[1], 1'b0};
    end else begin
      w_off = 2'b00;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = (w_is_half && lsu_addr[0]) ||
                 (!w_is_byte && !w_is_half && (lsu_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  always_comb begin
    w_lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'b0, w_lane[7:0]};
      3'b101:  w_load_ext = {16'b0, w_lane[15:0]};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          f3_d    = lsu_funct3;
          off_d   = w_off;
          load_d  = lsu_load;
          cnt_d   = '0;
          rdata_d = '0;
          fault_d = 1'b0;
          mis_d   = w_misalign;
          if (w_misalign) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            addr_d  = {lsu_addr[31:2], 2'b00};
            if (lsu_load) begin
              wdata_d = '0;
              wstrb_d = 4'b0000;
            end else if (w_is_byte) begin
              wdata_d = {4{lsu_wdata[7:0]}};
              wstrb_d = 4'b0001 << w_off;
            end else if (w_is_half) begin
              wdata_d = {2{lsu_wdata[15:0]}};
              wstrb_d = 4'b0011 << w_off;
            end else begin
              wdata_d = lsu_wdata;
              wstrb_d = 4'b1111;
            end
          end
        end
      end
      S_REQ: begin
        // A response arriving on the expiry cycle beats the timeout.
        if (mem_ready) begin
          state_d = S_DONE;
          rdata_d = load_q ? w_load_ext : 32'h0;
          fault_d = 1'b0;
        end else if ((MAX_WAIT != 0) && (cnt_q == c_last)) begin
          state_d = S_DONE;
          rdata_d = 32'h0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
    end
  end

  assign mem_valid    = (state_q == S_REQ);
  assign lsu_busy     = (state_q != S_IDLE);
  assign lsu_ready    = (state_q == S_DONE);
  assign lsu_rdata    = rdata_q;
  assign lsu_fault    = fault_q;
  assign lsu_misalign = mis_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu: transaction-level reference model,
//            directed corner cases plus randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_lsu;
  localparam int MW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsu_valid, lsu_load, lsu_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_ready, lsu_fault, lsu_misalign;
  logic [31:0] lsu_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  lsu #(.MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_ready(lsu_ready), .lsu_rdata(lsu_rdata),
    .lsu_fault(lsu_fault), .lsu_misalign(lsu_misalign),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        e_busy = 1'b0, e_mv = 1'b0, e_ready = 1'b0, e_fault = 1'b0, e_mis = 1'b0, e_store = 1'b0;
  logic [31:0] e_rdata = '0, e_addr = '0, e_wdata = '0;
  logic [3:0]  e_wstrb = '0;

  // Last values seen on the buses, for literal expectations.
  logic [31:0] cap_rdata = '0, cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        cap_fault = 1'b0, cap_mis = 1'b0;
  int          cap_mv = 0, cap_rdy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Load result from the architectural rules.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int          off;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        off = int'(a[1:0]);
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        off = a[1] ? 2 : 0;
        v = (w >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  initial forever begin
    @(negedge clock);
    if (mem_valid === 1'b1) begin
      cap_mv++;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
      cap_wstrb = mem_wstrb;
    end
    if (lsu_ready === 1'b1) begin
      cap_rdy++;
      cap_rdata = lsu_rdata;
      cap_fault = lsu_fault;
      cap_mis   = lsu_misalign;
    end
    if (chk_en) begin
      check("busy", 32'(lsu_busy), 32'(e_busy));
      check("mem_valid", 32'(mem_valid), 32'(e_mv));
      check("lsu_ready", 32'(lsu_ready), 32'(e_ready));
      if (e_mv) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (e_store) check("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_ready) begin
        check("lsu_fault", 32'(lsu_fault), 32'(e_fault));
        check("lsu_misalign", 32'(lsu_misalign), 32'(e_mis));
        check("lsu_rdata", lsu_rdata, e_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_exp();
    e_busy = 1'b0; e_mv = 1'b0; e_ready = 1'b0;
  endtask

  task automatic junk_req();
    lsu_valid  = 1'($urandom);
    lsu_load   = 1'($urandom);
    lsu_store  = 1'($urandom);
    lsu_funct3 = 3'($urandom);
    lsu_addr   = $urandom;
    lsu_wdata  = $urandom;
  endtask

  // Unacceptable request while idle: neither or both of load/store.
  task automatic idle_junk();
    logic b;
    b = 1'($urandom);
    junk_req();
    lsu_valid = 1'b1;
    lsu_load  = b;
    lsu_store = b;
    mem_ready = 1'($urandom);
    step();
    lsu_valid = 1'b0;
    idle_exp();
  endtask

  // One transaction; d = REQ cycles before mem_ready (d >= MW never answers).
  task automatic txn(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int d, input logic [31:0] mw);
    int          sz, off, k;
    logic        mis, flt;
    logic [31:0] ew;
    logic [3:0]  es;
    if (f3 == 3'b000 || (ld && f3 == 3'b100))      sz = 0;
    else if (f3 == 3'b001 || (ld && f3 == 3'b101)) sz = 1;
    else                                           sz = 2;
    off = (sz == 0) ? int'(a[1:0]) : (sz == 1) ? (a[1] ? 2 : 0) : 0;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`endif
    if (ld)           begin ew = '0; es = 4'h0; end
    else if (sz == 0) begin ew = {24'b0, wd[7:0]} * 32'h01010101; es = 4'(1 << off); end
    else if (sz == 1) begin ew = {16'b0, wd[15:0]} * 32'h00010001; es = 4'(3 << off); end
    else              begin ew = wd; es = 4'hF; end
    flt = (d >= MW);
    k   = flt ? MW - 1 : d;
    cap_mv = 0; cap_rdy = 0;

    lsu_valid = 1'b1; lsu_load = ld; lsu_store = !ld; lsu_funct3 = f3;
    lsu_addr = a; lsu_wdata = wd;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    idle_exp();
    if (mis) begin
      step(); junk_req(); mem_ready = 1'($urandom);
      e_busy = 1'b1; e_mv = 1'b0; e_ready = 1'b1;
      e_fault = 1'b0; e_mis = 1'b1; e_rdata = '0;
    end else begin
      for (int j = 0; j <= k; j++) begin
        step(); junk_req();
        e_busy = 1'b1; e_mv = 1'b1; e_ready = 1'b0; e_store = !ld;
        e_addr = {a[31:2], 2'b00}; e_wdata = ew; e_wstrb = es;
        mem_ready = (j == d);
        mem_rdata = (j == d) ? mw : $urandom;
      end
      step(); junk_req(); mem_ready = 1'($urandom); mem_rdata = $urandom;
      e_busy = 1'b1; e_mv = 1'b0; e_ready = 1'b1;
      e_fault = flt; e_mis = 1'b0;
      e_rdata = (ld && !flt) ? m_load(f3, a, mw) : 32'h0;
    end
    step();
    lsu_valid = 1'b0; mem_ready = 1'($urandom);
    idle_exp();
  endtask

  initial begin
    logic        ld;
    logic [2:0]  f3;
    reset = 1'b1;
    lsu_valid = 1'b0; lsu_load = 1'b0; lsu_store = 1'b0; lsu_funct3 = '0;
    lsu_addr = '0; lsu_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(lsu_busy), 0);
    check("rst_ready", 32'(lsu_ready), 0);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_fault", 32'(lsu_fault), 0);
    check("rst_misalign", 32'(lsu_misalign), 0);
    check("rst_rdata", lsu_rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", 32'(mem_wstrb), 0);
    reset = 1'b0;
    idle_exp();
    chk_en = 1'b1;

    txn(1'b1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_rdata", cap_rdata, 32'hDEADBEEF);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_wstrb", 32'(cap_wstrb), 0);
    check("lw_mv_cycles", cap_mv, 1);
    txn(1'b1, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
    check("lb_rdata", cap_rdata, 32'hFFFFFF80);
    txn(1'b1, 3'b100, 32'h103, 32'h0, 0, 32'h80112233);
    check("lbu_rdata", cap_rdata, 32'h00000080);
    txn(1'b1, 3'b101, 32'h102, 32'h0, 2, 32'h80112233);
    check("lhu_rdata", cap_rdata, 32'h00008011);
    txn(1'b0, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h0);
    check("sh_wdata", cap_wdata, 32'hABCDABCD);
    check("sh_wstrb", 32'(cap_wstrb), 32'hC);
    check("sh_mv_cycles", cap_mv, 4);
    check("sh_rdata", cap_rdata, 0);
    txn(1'b1, 3'b010, 32'h300, 32'h0, 100, 32'h0);
    check("to_fault", 32'(cap_fault), 1);
    check("to_rdata", cap_rdata, 0);
    check("to_mv_cycles", cap_mv, MW);
    txn(1'b1, 3'b010, 32'h300, 32'h0, MW - 1, 32'h55AA55AA);
    check("exp_fault", 32'(cap_fault), 0);
    check("exp_rdata", cap_rdata, 32'h55AA55AA);
    txn(1'b1, 3'b010, 32'h101, 32'h0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_flag", 32'(cap_mis), 1);
    check("mis_mv_cycles", cap_mv, 0);
`else
    check("mis_flag", 32'(cap_mis), 0);
    check("mis_addr", cap_addr, 32'h100);
    check("mis_rdata", cap_rdata, 32'hCAFEF00D);
`endif
    idle_junk();
    idle_junk();

    // Reset during REQ with a second request held on lsu_valid.
    cap_rdy = 0;
    lsu_valid = 1'b1; lsu_load = 1'b1; lsu_store = 1'b0; lsu_funct3 = 3'b010;
    lsu_addr = 32'h40; mem_ready = 1'b0;
    step();
    e_busy = 1'b1; e_mv = 1'b1; e_ready = 1'b0; e_store = 1'b0; e_addr = 32'h40; e_wstrb = 4'h0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_exp();
    step();
    e_busy = 1'b1; e_mv = 1'b1; e_ready = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    step();
    lsu_valid = 1'b0; mem_ready = 1'b0;
    e_busy = 1'b1; e_mv = 1'b0; e_ready = 1'b1; e_fault = 1'b0; e_mis = 1'b0;
    e_rdata = 32'h12345678;
    step();
    idle_exp();
    check("rst_abort_ready_count", cap_rdy, 1);

    for (int n = 0; n < 300; n++) begin
      ld = 1'($urandom);
      if (ld) begin
        case ($urandom_range(0, 7))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          4: f3 = 3'b101; 5: f3 = 3'b011; 6: f3 = 3'b110; default: f3 = 3'b010;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      txn(ld, f3, $urandom, $urandom, $urandom_range(0, MW + 1), $urandom);
      if ($urandom_range(0, 3) == 0) idle_junk();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
